wb_cmd_master: RTL and testbench

Upstream stage for the bus's Wishbone slaves. Converts a host command (read/write, start address, word count) into a sequence of single-word Wishbone classic cycles. Write data arrives on a ready/valid input stream; read data leaves on a ready/valid output stream. Sits between the host protocol decoder and the Wishbone interconnect.

---
 rtl/wb_cmd_pkg.sv | 12 +
 rtl/wb_timeout_counter.sv | 26 ++
 rtl/wb_cmd_master.sv | 139 +++++++++++++
 tb/tb_wb_cmd_master.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared constants for the Wishbone command master: FSM encoding, byte select, default timeout.
package wb_cmd_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_PUSH    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [3:0]  SEL_ALL         = 4'hF;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1000;
endpackage

// File: rtl/wb_timeout_counter.sv
// Clock counter guarding slave handshakes; expired is asserted on the clock whose
// edge would bring the count up to TIMEOUT, so a wait lasts exactly TIMEOUT clocks.
module wb_timeout_counter import wb_cmd_pkg::*; #(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [15:0] count_reg;

  // Restart on load, otherwise count clocks spent waiting on the slave
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expired = en && (count_reg == TIMEOUT - 16'd1);
endmodule

// File: rtl/wb_cmd_master.sv
// Turns a host command (we, start address, word count) into single-word Wishbone
// classic cycles. Write words come in on a ready/valid stream, read words leave on one.
module wb_cmd_master import wb_cmd_pkg::*; #(
  parameter logic [15:0] TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ADDR_INC = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  output logic        o_cmd_rdy,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_adr,
  input  logic [15:0] i_cmd_len,
  input  logic [31:0] i_wr_dat,
  input  logic        i_wr_stb,
  output logic        o_wr_rdy,
  output logic [31:0] o_rd_dat,
  output logic        o_rd_stb,
  input  logic        i_rd_rdy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wbs_cyc,
  output logic        o_wbs_stb,
  output logic        o_wbs_we,
  output logic [3:0]  o_wbs_sel,
  output logic [31:0] o_wbs_adr,
  output logic [31:0] o_wbs_dat,
  input  logic [31:0] i_wbs_dat,
  input  logic        i_wbs_ack,
  input  logic        i_wbs_int,
  output logic        o_int
);
  logic [2:0]  state_reg, state_next;
  logic        we_reg;
  logic [15:0] len_reg;
  logic [31:0] adr_reg, wdat_reg, rdat_reg;
  logic        err_reg, int_reg;
  // Held low during reset so o_cmd_rdy only rises the clock after reset releases
  logic        alive_reg;
  logic        cmd_acc, wr_acc, tmo_en, tmo_load, tmo_expired, tmo_abort;

  assign cmd_acc   = i_cmd_stb && o_cmd_rdy;
  assign wr_acc    = i_wr_stb && o_wr_rdy;
  assign tmo_en    = (state_reg == S_STROBE) || (state_reg == S_RELEASE);
  assign tmo_load  = (state_next != state_reg);
  // Timeout only matters while still waiting: ack missing in STROBE, ack stuck in RELEASE
  assign tmo_abort = tmo_expired &&
                     (((state_reg == S_STROBE) && !i_wbs_ack) ||
                      ((state_reg == S_RELEASE) && i_wbs_ack));

  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state decode for the per-word bus sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_acc) begin
          if (i_cmd_len == 16'd0) state_next = S_DONE;
          else if (i_cmd_we)      state_next = S_FETCH;
          else                    state_next = S_STROBE;
        end
      end
      S_FETCH: begin
        if (wr_acc) state_next = S_STROBE;
      end
      S_STROBE: begin
        if (i_wbs_ack)      state_next = S_RELEASE;
        else if (tmo_abort) state_next = S_DONE;
      end
      S_RELEASE: begin
        if (!i_wbs_ack) begin
          if (!we_reg)                  state_next = S_PUSH;
          else if (len_reg == 16'd1)    state_next = S_DONE;
          else                          state_next = S_FETCH;
        end else if (tmo_abort) begin
          state_next = S_DONE;
        end
      end
      S_PUSH: begin
        if (i_rd_rdy) state_next = (len_reg != 16'd0) ? S_STROBE : S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Command latches, data capture, address/count advance and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      alive_reg <= 1'b0;
      we_reg    <= 1'b0;
      len_reg   <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
      err_reg   <= 1'b0;
      int_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      alive_reg <= 1'b1;
      int_reg   <= i_wbs_int;
      if (cmd_acc) begin
        we_reg  <= i_cmd_we;
        adr_reg <= i_cmd_adr;
        len_reg <= i_cmd_len;
        err_reg <= 1'b0;
      end
      if (wr_acc) wdat_reg <= i_wr_dat;
      if ((state_reg == S_STROBE) && i_wbs_ack && !we_reg) rdat_reg <= i_wbs_dat;
      if ((state_reg == S_RELEASE) && !i_wbs_ack) begin
        len_reg <= len_reg - 16'd1;
        adr_reg <= adr_reg + ADDR_INC;
      end
      if (tmo_abort) err_reg <= 1'b1;
    end
  end

  assign o_cmd_rdy = alive_reg && (state_reg == S_IDLE);
  assign o_wr_rdy  = (state_reg == S_FETCH);
  assign o_rd_stb  = (state_reg == S_PUSH);
  assign o_done    = (state_reg == S_DONE);
  assign o_wbs_cyc = (state_reg == S_STROBE) || (state_reg == S_RELEASE);
  assign o_wbs_stb = (state_reg == S_STROBE);
  assign o_wbs_we  = o_wbs_cyc && we_reg;
  assign o_wbs_sel = o_wbs_stb ? SEL_ALL : 4'h0;
  assign o_wbs_adr = adr_reg;
  assign o_wbs_dat = wdat_reg;
  assign o_rd_dat  = rdat_reg;
  assign o_err     = err_reg;
  assign o_int     = int_reg;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed commands push expected bus words,
// read words and done pulses into queues; a monitor pops and compares them.
module tb_wb_cmd_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_stb = 1'b0, i_cmd_we = 1'b0;
  logic [31:0] i_cmd_adr = '0;
  logic [15:0] i_cmd_len = '0;
  logic [31:0] i_wr_dat = '0;
  logic        i_wr_stb = 1'b0;
  logic        i_rd_rdy;
  logic [31:0] i_wbs_dat;
  logic        i_wbs_ack;
  logic        i_wbs_int = 1'b0;
  logic        o_cmd_rdy, o_wr_rdy, o_rd_stb, o_done, o_err;
  logic        o_wbs_cyc, o_wbs_stb, o_wbs_we, o_int;
  logic [3:0]  o_wbs_sel;
  logic [31:0] o_rd_dat, o_wbs_adr, o_wbs_dat;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(16'd8), .ADDR_INC(32'd1)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_we(i_cmd_we),
    .i_cmd_adr(i_cmd_adr), .i_cmd_len(i_cmd_len),
    .i_wr_dat(i_wr_dat), .i_wr_stb(i_wr_stb), .o_wr_rdy(o_wr_rdy),
    .o_rd_dat(o_rd_dat), .o_rd_stb(o_rd_stb), .i_rd_rdy(i_rd_rdy),
    .o_done(o_done), .o_err(o_err),
    .o_wbs_cyc(o_wbs_cyc), .o_wbs_stb(o_wbs_stb), .o_wbs_we(o_wbs_we),
    .o_wbs_sel(o_wbs_sel), .o_wbs_adr(o_wbs_adr), .o_wbs_dat(o_wbs_dat),
    .i_wbs_dat(i_wbs_dat), .i_wbs_ack(i_wbs_ack),
    .i_wbs_int(i_wbs_int), .o_int(o_int)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  int total = 0;
  int bad   = 0;

  // Slave and consumer knobs
  int          ack_delay = 1;
  int          ack_hold  = 0;
  bit          never_ack = 1'b0;
  logic [31:0] rd_xor    = '0;
  int          rd_delay  = 0;
  int          stb_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wishbone slave: acks ack_delay clocks after stb, holds ack ack_hold clocks after stb drops
  initial begin : slave
    int stb_cnt;
    int hold_cnt;
    stb_cnt = 0;
    hold_cnt = 0;
    i_wbs_ack = 1'b0;
    i_wbs_dat = '0;
    forever begin
      tick();
      if (o_wbs_stb) begin
        hold_cnt = 0;
        if (!i_wbs_ack) begin
          stb_cnt++;
          if (!never_ack && stb_cnt > ack_delay) begin
            i_wbs_ack = 1'b1;
            i_wbs_dat = o_wbs_we ? 32'h0 : (o_wbs_adr ^ rd_xor);
          end
        end
      end else begin
        stb_cnt = 0;
        if (i_wbs_ack) begin
          hold_cnt++;
          if (hold_cnt > ack_hold) begin
            i_wbs_ack = 1'b0;
            i_wbs_dat = '0;
          end
        end
      end
    end
  end

  // Read consumer: keeps i_rd_rdy low for rd_delay clocks of each o_rd_stb
  initial begin : consumer
    int rd_wait;
    rd_wait = 0;
    i_rd_rdy = 1'b0;
    forever begin
      tick();
      if (o_rd_stb) begin
        if (rd_wait < rd_delay) begin
          i_rd_rdy = 1'b0;
          rd_wait++;
        end else begin
          i_rd_rdy = 1'b1;
        end
      end else begin
        i_rd_rdy = 1'b0;
        rd_wait = 0;
      end
    end
  end

  // Monitor: compares every completed bus word, read word and done pulse
  initial begin : monitor
    bus_t        e;
    logic [31:0] r;
    logic        d;
    logic        stb_prev;
    logic        rd_hold_v;
    logic [31:0] rd_hold_dat;
    stb_prev = 1'b0;
    rd_hold_v = 1'b0;
    rd_hold_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stb_prev = 1'b0;
        rd_hold_v = 1'b0;
      end else begin
        if (o_wbs_stb) stb_cycles++;
        if (o_wbs_stb && !stb_prev) begin
          chk("stb_rise_ack_low", {31'd0, i_wbs_ack}, 32'd0);
          chk("stb_sel", {28'd0, o_wbs_sel}, 32'hF);
          chk("stb_cyc", {31'd0, o_wbs_cyc}, 32'd1);
        end
        stb_prev = o_wbs_stb;
        if (o_wbs_stb && i_wbs_ack) begin
          if (exp_bus.size() == 0) begin
            flag("bus_word_extra");
          end else begin
            e = exp_bus.pop_front();
            $display("bus  we=%0d adr=%h dat=%h", o_wbs_we, o_wbs_adr, o_wbs_we ? o_wbs_dat : i_wbs_dat);
            chk("bus_we", {31'd0, o_wbs_we}, {31'd0, e.we});
            chk("bus_adr", o_wbs_adr, e.adr);
            if (e.we) chk("bus_wdat", o_wbs_dat, e.dat);
          end
        end
        if (rd_hold_v) begin
          chk("rd_stb_held", {31'd0, o_rd_stb}, 32'd1);
          chk("rd_dat_stable", o_rd_dat, rd_hold_dat);
        end
        if (o_rd_stb) chk("no_stb_in_push", {31'd0, o_wbs_stb}, 32'd0);
        rd_hold_v = o_rd_stb && !i_rd_rdy;
        rd_hold_dat = o_rd_dat;
        if (o_rd_stb && i_rd_rdy) begin
          if (exp_rd.size() == 0) begin
            flag("rd_word_extra");
          end else begin
            r = exp_rd.pop_front();
            $display("rd   dat=%h", o_rd_dat);
            chk("rd_dat", o_rd_dat, r);
          end
        end
        if (o_done) begin
          if (exp_done.size() == 0) begin
            flag("done_extra");
          end else begin
            d = exp_done.pop_front();
            $display("done err=%0d", o_err);
            chk("done_err", {31'd0, o_err}, {31'd0, d});
            chk("done_cyc_low", {31'd0, o_wbs_cyc}, 32'd0);
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [15:0] len);
    int n;
    n = 0;
    i_cmd_we = we;
    i_cmd_adr = adr;
    i_cmd_len = len;
    i_cmd_stb = 1'b1;
    @(negedge clk);
    while (!o_cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_rdy) $display("FAIL cmd_accept: o_cmd_rdy=0, required 1 within 50 clks");
    chk("cmd_accept", {31'd0, o_cmd_rdy}, 32'd1);
    tick();
    i_cmd_stb = 1'b0;
    chk("err_clear_on_accept", {31'd0, o_err}, 32'd0);
  endtask

  task automatic feed(input logic [31:0] d);
    int n;
    n = 0;
    i_wr_dat = d;
    i_wr_stb = 1'b1;
    @(negedge clk);
    while (!o_wr_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_accept", {31'd0, o_wr_rdy}, 32'd1);
    tick();
    i_wr_stb = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_done.size() + exp_bus.size() + exp_rd.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, exp_done.size() + exp_bus.size() + exp_rd.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, {19'd0, o_cmd_rdy, o_wr_rdy, o_rd_stb, o_done, o_err,
                          o_wbs_cyc, o_wbs_stb, o_wbs_we, o_wbs_sel, o_int}, 32'd0);
    chk({name, "_adr"}, o_wbs_adr, 32'd0);
    chk({name, "_wdat"}, o_wbs_dat, 32'd0);
    chk({name, "_rdat"}, o_rd_dat, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    logic seen;

    // Reset state, o_cmd_rdy rising one clock after release, o_int one-clock delay
    i_wbs_int = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_rdy_still_low", {31'd0, o_cmd_rdy}, 32'd0);
    @(negedge clk);
    chk("cmd_rdy_after_reset", {31'd0, o_cmd_rdy}, 32'd1);
    chk("int_delayed", {31'd0, o_int}, 32'd1);
    i_wbs_int = 1'b0;
    tick();
    @(negedge clk);
    chk("int_cleared", {31'd0, o_int}, 32'd0);

    // Write len=3 at 0
    exp_done.push_back(1'b0);
    exp_bus.push_back('{1'b1, 32'h0, 32'hA0});
    exp_bus.push_back('{1'b1, 32'h1, 32'hA1});
    exp_bus.push_back('{1'b1, 32'h2, 32'hA2});
    tick();
    fork
      send_cmd(1'b1, 32'h0, 16'd3);
      begin
        feed(32'hA0);
        feed(32'hA1);
        feed(32'hA2);
      end
    join
    wait_drain("write3");

    // Read len=2 at 0x10 with a slow consumer
    rd_delay = 5;
    exp_done.push_back(1'b0);
    exp_bus.push_back('{1'b0, 32'h10, 32'h0});
    exp_bus.push_back('{1'b0, 32'h11, 32'h0});
    exp_rd.push_back(32'h10);
    exp_rd.push_back(32'h11);
    tick();
    send_cmd(1'b0, 32'h10, 16'd2);
    wait_drain("read2");
    rd_delay = 0;

    // Read across the 32-bit address wrap
    rd_xor = 32'h5A5A0000;
    exp_done.push_back(1'b0);
    exp_bus.push_back('{1'b0, 32'hFFFFFFFF, 32'h0});
    exp_bus.push_back('{1'b0, 32'h00000000, 32'h0});
    exp_rd.push_back(32'hA5A5FFFF);
    exp_rd.push_back(32'h5A5A0000);
    tick();
    send_cmd(1'b0, 32'hFFFFFFFF, 16'd2);
    wait_drain("read_wrap");
    rd_xor = '0;

    // Timeout: slave never acks
    never_ack = 1'b1;
    stb_cycles = 0;
    exp_done.push_back(1'b1);
    tick();
    send_cmd(1'b0, 32'h40, 16'd1);
    wait_drain("timeout");
    chk("timeout_stb_cycles", stb_cycles, 32'd8);
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    never_ack = 1'b0;

    // len=0: no bus activity, done shortly after accept, error cleared
    stb_cycles = 0;
    exp_done.push_back(1'b0);
    tick();
    send_cmd(1'b0, 32'h50, 16'd0);
    n = 0;
    @(negedge clk);
    seen = o_done;
    while (!seen && n < 1) begin
      @(negedge clk);
      seen = o_done;
      n++;
    end
    chk("len0_done_latency", {31'd0, seen}, 32'd1);
    wait_drain("len0");
    chk("len0_no_stb", stb_cycles, 32'd0);

    // Slave holds ack 3 clocks after stb drops
    ack_hold = 3;
    exp_done.push_back(1'b0);
    exp_bus.push_back('{1'b1, 32'h20, 32'hB0});
    exp_bus.push_back('{1'b1, 32'h21, 32'hB1});
    tick();
    fork
      send_cmd(1'b1, 32'h20, 16'd2);
      begin
        feed(32'hB0);
        feed(32'hB1);
      end
    join
    wait_drain("hold_ack");
    chk("hold_ack_final_adr", o_wbs_adr, 32'h22);
    ack_hold = 0;

    // Reset during the second word of a len=4 write
    exp_bus.push_back('{1'b1, 32'h30, 32'hC0});
    exp_bus.push_back('{1'b1, 32'h31, 32'hC1});
    tick();
    fork
      send_cmd(1'b1, 32'h30, 16'd4);
      begin
        feed(32'hC0);
        feed(32'hC1);
      end
    join
    n = 0;
    while (!(o_wbs_stb && o_wbs_adr == 32'h31) && n < 20) begin
      tick();
      n++;
    end
    chk("second_word_stb", {31'd0, o_wbs_stb}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    exp_bus.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_rdy_after_mid_reset", {31'd0, o_cmd_rdy}, 32'd1);
    repeat (5) @(negedge clk);
    chk("no_pending_after_reset", exp_done.size() + exp_rd.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
